// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard/forwarding control bundle between the pipeline datapath and pipeline_ctrl
//
// master: the pipeline datapath (drives stage indices and flags, receives control)
// slave : pipeline_ctrl (receives stage indices and flags, drives control)
//   id_rs1/id_rs2                      source registers of the instruction in ID
//   exe_rs1/exe_rs2                    source registers of the instruction in EXE
//   exe_rd/exe_reg_write/exe_mem_load  destination, write-enable, load flag in EXE
//   mem_rd/mem_reg_write               destination and write-enable in MEM
//   wb_rd/wb_reg_write                 destination and write-enable in WB
//   pc_src                             taken branch/jump resolved in EXE
//   md_start/md_done                   multi-cycle mul/div in EXE; its result is ready
//   fwd_rs1/fwd_rs2                    EXE operand select (10 MEM, 01 WB, 00 regfile)
//   stall_if/stall_id/stall_exe        hold PC, IF/ID, ID/EXE
//   flush_id/flush_exe                 bubble IF/ID, ID/EXE
//   md_busy                            mul/div wait in progress
//   perf_stalls/perf_flushes           performance counters
interface pipeline_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  exe_rs1;
    logic [4:0]  exe_rs2;
    logic [4:0]  exe_rd;
    logic        exe_reg_write;
    logic        exe_mem_load;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        pc_src;
    logic        md_start;
    logic        md_done;
    logic [1:0]  fwd_rs1;
    logic [1:0]  fwd_rs2;
    logic        stall_if;
    logic        stall_id;
    logic        stall_exe;
    logic        flush_id;
    logic        flush_exe;
    logic        md_busy;
    logic [31:0] perf_stalls;
    logic [31:0] perf_flushes;

    modport master (
        output id_rs1, id_rs2, exe_rs1, exe_rs2, exe_rd, exe_reg_write, exe_mem_load,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, pc_src, md_start, md_done,
        input  fwd_rs1, fwd_rs2, stall_if, stall_id, stall_exe, flush_id, flush_exe,
               md_busy, perf_stalls, perf_flushes
    );

    modport slave (
        input  id_rs1, id_rs2, exe_rs1, exe_rs2, exe_rd, exe_reg_write, exe_mem_load,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, pc_src, md_start, md_done,
        output fwd_rs1, fwd_rs2, stall_if, stall_id, stall_exe, flush_id, flush_exe,
               md_busy, perf_stalls, perf_flushes
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard unit: operand forwarding, stall/flush control, mul/div wait FSM
//
// Ports:
//   clk  pipeline clock, rising edge
//   rst  synchronous active-high reset
//   bus  pipeline_ctrl_if.slave (stage indices/flags in, forward selects, stalls,
//        flushes, md_busy and perf counters out)
// Build option:
//   PIPE_CTRL_PERF_EN  when defined, perf_stalls counts cycles with stall_if=1 and
//                      perf_flushes counts cycles with flush_id=1 (both wrap);
//                      otherwise both ports are tied to zero.
module pipeline_ctrl (
    input  logic         clk,
    input  logic         rst,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic load_use;
    logic stall_if_d;
    logic stall_id_d;
    logic stall_exe_d;
    logic flush_id_d;
    logic flush_exe_d;

    // MEM is the younger producer, so its result shadows WB for the same register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == rs))
            return 2'b10;
        else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign bus.fwd_rs1 = fwd_sel(bus.exe_rs1);
    assign bus.fwd_rs2 = fwd_sel(bus.exe_rs2);

    assign load_use = bus.exe_mem_load && bus.exe_reg_write && (bus.exe_rd != 5'd0) &&
                      ((bus.exe_rd == bus.id_rs1) || (bus.exe_rd == bus.id_rs2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_if_d  = 1'b0;
        stall_id_d  = 1'b0;
        stall_exe_d = 1'b0;
        flush_id_d  = 1'b0;
        flush_exe_d = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.md_start) begin
                    // A mul/div that finishes in its first cycle needs no freeze.
                    if (!bus.md_done) begin
                        stall_if_d  = 1'b1;
                        stall_id_d  = 1'b1;
                        stall_exe_d = 1'b1;
                        state_d     = MD_WAIT;
                    end
                end else if (bus.pc_src) begin
                    // The redirect kills the dependent instruction, so no load-use stall.
                    flush_id_d  = 1'b1;
                    flush_exe_d = 1'b1;
                end else if (load_use) begin
                    // Hold IF/ID and push a bubble into EXE; the load then reaches WB
                    // when the consumer is in EXE and forwards via 2'b01.
                    stall_if_d  = 1'b1;
                    stall_id_d  = 1'b1;
                    flush_exe_d = 1'b1;
                end
            end
            MD_WAIT: begin
                if (bus.md_done) begin
                    state_d = RUN;
                end else begin
                    stall_if_d  = 1'b1;
                    stall_id_d  = 1'b1;
                    stall_exe_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (rst) begin
            stall_if_d  = 1'b0;
            stall_id_d  = 1'b0;
            stall_exe_d = 1'b0;
            flush_id_d  = 1'b0;
            flush_exe_d = 1'b0;
        end
    end

    assign bus.stall_if  = stall_if_d;
    assign bus.stall_id  = stall_id_d;
    assign bus.stall_exe = stall_exe_d;
    assign bus.flush_id  = flush_id_d;
    assign bus.flush_exe = flush_exe_d;
    assign bus.md_busy   = (state_q == MD_WAIT);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stalls_q;
    logic [31:0] perf_stalls_d;
    logic [31:0] perf_flushes_q;
    logic [31:0] perf_flushes_d;

    // Stall/flush are already forced low during reset, so no extra gating here.
    assign perf_stalls_d  = perf_stalls_q + {31'd0, stall_if_d};
    assign perf_flushes_d = perf_flushes_q + {31'd0, flush_id_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stalls_q  <= 32'd0;
            perf_flushes_q <= 32'd0;
        end else begin
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign bus.perf_stalls  = perf_stalls_q;
    assign bus.perf_flushes = perf_flushes_q;
`else
    assign bus.perf_stalls  = 32'd0;
    assign bus.perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec;
    int n_err;
    bit run_cmp;
    bit preload_req;

    // Model state: is a multi-cycle op outstanding, and how many events were counted.
    bit          md_pend;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Priority-ordered source list: first matching producer supplies the operand.
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        logic [4:0] rd [2];
        logic       we [2];
        logic [1:0] code [2];
        rd[0] = bus.mem_rd; we[0] = bus.mem_reg_write; code[0] = 2'b10;
        rd[1] = bus.wb_rd;  we[1] = bus.wb_reg_write;  code[1] = 2'b01;
        for (int k = 0; k < 2; k++)
            if (we[k] && rd[k] != 0 && rd[k] == rs) return code[k];
        return 2'b00;
    endfunction

    // Expected {stall_if, stall_id, stall_exe, flush_id, flush_exe}
    function automatic logic [4:0] m_ctrl();
        bit hazard, freeze, redirect, bubble;
        hazard   = bus.exe_mem_load && bus.exe_reg_write && bus.exe_rd != 0 &&
                   (bus.exe_rd == bus.id_rs1 || bus.exe_rd == bus.id_rs2);
        freeze   = md_pend ? !bus.md_done : (bus.md_start && !bus.md_done);
        redirect = !md_pend && !bus.md_start && bus.pc_src;
        bubble   = !md_pend && !bus.md_start && !bus.pc_src && hazard;
        if (rst) return 5'b0;
        return {freeze || bubble, freeze || bubble, freeze, redirect, redirect || bubble};
    endfunction

    always @(posedge clk) begin
        logic [4:0]  c;
        logic [31:0] base;
        c = m_ctrl();
        base = preload_req ? 32'hFFFF_FFFF : m_stalls;
        if (rst) begin
            md_pend   = 1'b0;
            m_stalls  = 32'd0;
            m_flushes = 32'd0;
        end else begin
            if (md_pend) md_pend = !bus.md_done;
            else         md_pend = bus.md_start && !bus.md_done;
            m_stalls  = base + (c[4] ? 32'd1 : 32'd0);
            m_flushes = m_flushes + (c[1] ? 32'd1 : 32'd0);
        end
    end

    always @(negedge clk) begin
        logic [4:0] c;
        if (run_cmp) begin
            c = m_ctrl();
            check("fwd_rs1",   {30'd0, bus.fwd_rs1}, {30'd0, m_fwd(bus.exe_rs1)});
            check("fwd_rs2",   {30'd0, bus.fwd_rs2}, {30'd0, m_fwd(bus.exe_rs2)});
            check("stall_if",  {31'd0, bus.stall_if},  {31'd0, c[4]});
            check("stall_id",  {31'd0, bus.stall_id},  {31'd0, c[3]});
            check("stall_exe", {31'd0, bus.stall_exe}, {31'd0, c[2]});
            check("flush_id",  {31'd0, bus.flush_id},  {31'd0, c[1]});
            check("flush_exe", {31'd0, bus.flush_exe}, {31'd0, c[0]});
            check("md_busy",   {31'd0, bus.md_busy},   {31'd0, md_pend});
            check("perf_stalls",  bus.perf_stalls,
                  PERF ? (preload_req ? 32'hFFFF_FFFF : m_stalls) : 32'd0);
            check("perf_flushes", bus.perf_flushes, PERF ? m_flushes : 32'd0);
        end
    end

    task automatic clear_in();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.exe_rs1 = 0; bus.exe_rs2 = 0;
        bus.exe_rd = 0; bus.exe_reg_write = 0; bus.exe_mem_load = 0;
        bus.mem_rd = 0; bus.mem_reg_write = 0; bus.wb_rd = 0; bus.wb_reg_write = 0;
        bus.pc_src = 0; bus.md_start = 0; bus.md_done = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        bus.exe_mem_load = 1; bus.exe_reg_write = 1; bus.exe_rd = 7; bus.id_rs2 = 7;
    endtask

    // {exe_rs1, exe_rs2, mem_rd, mem_we, wb_rd, wb_we, exp_fwd1, exp_fwd2}
    typedef struct {
        logic [4:0] rs1, rs2, mrd; logic mwe; logic [4:0] wrd; logic wwe;
        logic [1:0] f1, f2;
    } fvec_t;
    fvec_t fv [5];

    initial begin
        fv[0] = '{5'd3,  5'd4,  5'd3,  1'b1, 5'd4,  1'b1, 2'b10, 2'b01};
        fv[1] = '{5'd3,  5'd3,  5'd3,  1'b0, 5'd3,  1'b1, 2'b01, 2'b01};
        fv[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'b00, 2'b00};
        fv[3] = '{5'd31, 5'd12, 5'd12, 1'b1, 5'd31, 1'b0, 2'b00, 2'b10};
        fv[4] = '{5'd8,  5'd9,  5'd9,  1'b1, 5'd8,  1'b1, 2'b01, 2'b10};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; run_cmp = 0; preload_req = 0;
        md_pend = 0; m_stalls = 0; m_flushes = 0;
        rst = 1'b1;
        clear_in();
        next_cycle();
        run_cmp = 1;
        @(negedge clk);
        check("reset md_busy", {31'd0, bus.md_busy}, 32'd0);
        check("reset perf_stalls", bus.perf_stalls, 32'd0);
        check("reset stall_if", {31'd0, bus.stall_if}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Forwarding
        bus.exe_rs1 = 5; bus.mem_rd = 5; bus.wb_rd = 5;
        bus.mem_reg_write = 1; bus.wb_reg_write = 1; #1;
        check("fwd mem wins", {30'd0, bus.fwd_rs1}, 32'd2);
        bus.mem_rd = 0; #1;
        check("fwd wb", {30'd0, bus.fwd_rs1}, 32'd1);
        bus.exe_rs2 = 0; bus.wb_rd = 0; #1;
        check("fwd x0", {30'd0, bus.fwd_rs2}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            bus.exe_rs1 = fv[i].rs1; bus.exe_rs2 = fv[i].rs2;
            bus.mem_rd = fv[i].mrd; bus.mem_reg_write = fv[i].mwe;
            bus.wb_rd = fv[i].wrd; bus.wb_reg_write = fv[i].wwe;
            #1;
            check($sformatf("fwd_tab%0d rs1", i), {30'd0, bus.fwd_rs1}, {30'd0, fv[i].f1});
            check($sformatf("fwd_tab%0d rs2", i), {30'd0, bus.fwd_rs2}, {30'd0, fv[i].f2});
        end

        // Load-use: one bubble, then clean
        next_cycle(); clear_in(); set_load_use();
        @(negedge clk);
        check("lu stall_if",  {31'd0, bus.stall_if},  32'd1);
        check("lu stall_id",  {31'd0, bus.stall_id},  32'd1);
        check("lu flush_exe", {31'd0, bus.flush_exe}, 32'd1);
        check("lu stall_exe", {31'd0, bus.stall_exe}, 32'd0);
        next_cycle(); clear_in(); bus.exe_rs2 = 7; bus.wb_rd = 7; bus.wb_reg_write = 1;
        @(negedge clk);
        check("lu clean stall_if", {31'd0, bus.stall_if}, 32'd0);
        check("lu consumer fwd", {30'd0, bus.fwd_rs2}, 32'd1);
        check("lu perf_stalls", bus.perf_stalls, PERF ? 32'd1 : 32'd0);

        // Branch over load-use
        next_cycle(); clear_in(); set_load_use(); bus.pc_src = 1;
        @(negedge clk);
        check("br flush_id",  {31'd0, bus.flush_id},  32'd1);
        check("br flush_exe", {31'd0, bus.flush_exe}, 32'd1);
        check("br stall_if",  {31'd0, bus.stall_if},  32'd0);
        next_cycle(); clear_in();
        @(negedge clk);
        check("br perf_flushes", bus.perf_flushes, PERF ? 32'd1 : 32'd0);

        // Mul/div: start, three wait cycles (pc_src and hazard ignored), done on the fourth
        next_cycle(); clear_in(); bus.md_start = 1;
        @(negedge clk);
        check("md start stall_exe", {31'd0, bus.stall_exe}, 32'd1);
        check("md start busy", {31'd0, bus.md_busy}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle(); clear_in();
            if (i == 2) begin bus.pc_src = 1; set_load_use(); end
            @(negedge clk);
            check($sformatf("md wait%0d stall_exe", i), {31'd0, bus.stall_exe}, 32'd1);
            check($sformatf("md wait%0d busy", i), {31'd0, bus.md_busy}, 32'd1);
            check($sformatf("md wait%0d flush_id", i), {31'd0, bus.flush_id}, 32'd0);
        end
        next_cycle(); clear_in(); bus.md_done = 1;
        @(negedge clk);
        check("md done stall_if", {31'd0, bus.stall_if}, 32'd0);
        check("md done busy", {31'd0, bus.md_busy}, 32'd1);
        next_cycle(); clear_in();
        @(negedge clk);
        check("md after busy", {31'd0, bus.md_busy}, 32'd0);
        check("md perf_stalls", bus.perf_stalls, PERF ? 32'd5 : 32'd0);

        // Single-cycle mul/div, and md_start beating pc_src
        next_cycle(); clear_in(); bus.md_start = 1; bus.md_done = 1;
        @(negedge clk);
        check("md1 stall_exe", {31'd0, bus.stall_exe}, 32'd0);
        next_cycle(); clear_in(); bus.md_start = 1; bus.pc_src = 1;
        @(negedge clk);
        check("md1 busy", {31'd0, bus.md_busy}, 32'd0);
        check("md over br flush_id", {31'd0, bus.flush_id}, 32'd0);
        check("md over br stall_if", {31'd0, bus.stall_if}, 32'd1);

        // Reset in the second MD_WAIT cycle
        next_cycle(); clear_in();
        @(negedge clk);
        check("rst pre busy", {31'd0, bus.md_busy}, 32'd1);
        next_cycle(); clear_in(); rst = 1;
        @(negedge clk);
        check("rst stall_if", {31'd0, bus.stall_if}, 32'd0);
        check("rst stall_exe", {31'd0, bus.stall_exe}, 32'd0);
        next_cycle(); rst = 0;
        @(negedge clk);
        check("rst post busy", {31'd0, bus.md_busy}, 32'd0);
        check("rst post perf_stalls", bus.perf_stalls, 32'd0);
        check("rst post perf_flushes", bus.perf_flushes, 32'd0);

`ifdef PIPE_CTRL_PERF_EN
        // Counter wrap
        next_cycle(); clear_in(); set_load_use();
        force dut.perf_stalls_q = 32'hFFFF_FFFF;
        preload_req = 1;
        #1 release dut.perf_stalls_q;
        @(negedge clk);
        check("wrap pre", bus.perf_stalls, 32'hFFFF_FFFF);
        next_cycle(); clear_in(); preload_req = 0;
        @(negedge clk);
        check("wrap perf_stalls", bus.perf_stalls, 32'd0);
`endif

        next_cycle();
        run_cmp = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
